// File: rtl/counter_sync_pkg.sv
// counter_sync_pkg
//   Shared constants for the counter_sync block, used by both RTL and benches.
//   DEFAULT_WIDTH : default counter width
//   COUNT_RESET   : value loaded while reset is asserted (all zeros; cast to
//                   the instance width at the point of use)
package counter_sync_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int COUNT_RESET   = 0;

endpackage

// File: rtl/counter_sync_incr.sv
// counter_sync_incr
//   Purely combinational +1 built from a ripple chain of half-adder cells.
//   Cell i adds a[i] and carry[i]; carry[0] is tied to 1 so the chain
//   increments by one.
//   Ports:
//     a         [WIDTH] in  : operand
//     sum       [WIDTH] out : (a + 1) mod 2^WIDTH
//     carry_out         out : carry from the top cell (high only when a is all ones)
module counter_sync_incr
  import counter_sync_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum[i]     = a[i] ^ carry[i];
    assign carry[i+1] = a[i] & carry[i];
  end

  assign carry_out = carry[WIDTH];

endmodule

// File: rtl/counter_sync.sv
// counter_sync
//   Free-running WIDTH-bit up-counter with synchronous active-low reset.
//   The count wraps silently from all ones to zero.
//   Ports:
//     clock          in  : single clock, all updates on the rising edge
//     reset          in  : synchronous, active-low; loads zero when sampled low
//     out   [WIDTH]  out : count register, no combinational path from inputs
module counter_sync
  import counter_sync_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] out
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "counter_sync: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] incr_sum;
  // Carry-out of the incrementer is intentionally dropped: wrap has no flag.
  logic             carry_unused;

  counter_sync_incr #(
    .WIDTH(WIDTH)
  ) u_incr (
    .a        (out),
    .sum      (incr_sum),
    .carry_out(carry_unused)
  );

  always_ff @(posedge clock) begin
    if (!reset) out <= WIDTH'(COUNT_RESET);
    else        out <= incr_sum;
  end

endmodule

// File: tb/tb_counter_sync.sv
module tb_counter_sync;
  import counter_sync_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] out4;
  logic [0:0] out1;
  logic [7:0] out8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] exp4;
    logic [0:0] exp1;
    logic [7:0] exp8;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n = 0;     // edges since the last sampled reset
  bit   done = 0;

  counter_sync #(DEFAULT_WIDTH) dut4 (.clock(clk), .reset(rst_n), .out(out4));
  counter_sync #(1)             dut1 (.clock(clk), .reset(rst_n), .out(out1));
  counter_sync #(8)             dut8 (.clock(clk), .reset(rst_n), .out(out8));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: at each falling edge, compare the outputs produced by the
  // preceding rising edge against the expectation queued for it.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (out4 !== cur.exp4) begin
        errors++;
        $display("FAIL %s w4: got %0d expected %0d", cur.name, out4, cur.exp4);
      end
      checks++;
      if (out1 !== cur.exp1) begin
        errors++;
        $display("FAIL %s w1: got %0d expected %0d", cur.name, out1, cur.exp1);
      end
      checks++;
      if (out8 !== cur.exp8) begin
        errors++;
        $display("FAIL %s w8: got %0d expected %0d", cur.name, out8, cur.exp8);
      end
    end
  end

  // Issue one edge: drive reset for the next rising edge and queue the result.
  task automatic step(input logic r, input logic [3:0] e4, input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = r;
    if (!r) n = 0;
    else    n++;
    e.exp4 = e4;
    e.exp1 = 1'(n);
    e.exp8 = 8'(n);
    e.name = nm;
    sb.push_back(e);
  endtask

  // As step with reset high, but a low glitch on reset lands between edges.
  task automatic step_glitch(input logic [3:0] e4);
    step(1'b1, e4, "sync_glitch");
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  logic [3:0] run_exp [20] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                               4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13,
                               4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

  initial begin
    rst_n = 1'b0;

    // Reset hold for 3 edges
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, "reset_hold");

    // Count run: reset at the first edge, then 20 counting edges
    step(1'b0, 4'd0, "run_reset");
    for (int i = 0; i < 20; i++) step(1'b1, run_exp[i], "count_run");

    // Mid-count reset at 9
    step(1'b1, 4'd5, "to_nine");
    step(1'b1, 4'd6, "to_nine");
    step(1'b1, 4'd7, "to_nine");
    step(1'b1, 4'd8, "to_nine");
    step(1'b1, 4'd9, "to_nine");
    step(1'b0, 4'd0, "mid_reset");
    step(1'b1, 4'd1, "release");

    // Wrap 15 -> 0 -> 1
    for (int i = 2; i < 16; i++) step(1'b1, 4'(i), "to_fifteen");
    step(1'b1, 4'd0, "wrap");
    step(1'b1, 4'd1, "after_wrap");

    // Reset pulses between edges must be ignored
    step_glitch(4'd2);
    step_glitch(4'd3);
    step_glitch(4'd4);
    step_glitch(4'd5);

    // 8-bit wrap: reset, then 256 edges; the last returns to 0 at width 8
    step(1'b0, 4'd0, "w8_reset");
    for (int i = 1; i <= 254; i++) step(1'b1, 4'(i % 16), "w8_climb");
    step(1'b1, 4'd15, "w8_at_255");
    step(1'b1, 4'd0, "w8_wrap");
    step(1'b1, 4'd1, "w8_after_wrap");

    repeat (3) @(negedge clk);
    done = 1;
  end

  initial begin
    fork
      wait (done);
      #200000;
    join_any
    disable fork;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus done=%0d expected 1", done);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
